// File: rtl/mem_bus_arbiter_if.sv
// Processor-side memory bus shared by the icache and dcache controllers.
// The arbiter connects through the slave modport. The master modport is the
// mirror view, for a block that drives the requests and memory responses.
interface mem_bus_arbiter_if;
    logic [1:0]  icache_command;
    logic [31:0] icache_addr;
    logic [1:0]  dcache_command;
    logic [31:0] dcache_addr;
    logic [63:0] dcache_wdata;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  icache_response;
    logic [3:0]  dcache_response;
    logic [3:0]  icache_tag;
    logic [3:0]  dcache_tag;
    logic [63:0] icache_data;
    logic [63:0] dcache_data;
    logic [14:0] outstanding;
    logic        tag_error;

    modport slave (
        input  icache_command, icache_addr, dcache_command, dcache_addr, dcache_wdata,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
               icache_response, dcache_response, icache_tag, dcache_tag,
               icache_data, dcache_data, outstanding, tag_error
    );

    modport master (
        output icache_command, icache_addr, dcache_command, dcache_addr, dcache_wdata,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
               icache_response, dcache_response, icache_tag, dcache_tag,
               icache_data, dcache_data, outstanding, tag_error
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbiter for the single processor-to-memory bus, shared by icache and dcache.
// The dcache has priority. The icache is forced to win after STARVE_LIMIT lost
// cycles in a row. A 15-entry tag table records which requester owns each
// outstanding load, so each completion is delivered only to its owner.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0]    BUS_NONE   = 2'd0;
    localparam logic [1:0]    BUS_LOAD   = 2'd1;
    localparam int unsigned   CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_starve_cnt;
    logic [15:1]   r_valid;
    logic [15:1]   r_owner;
    logic          r_tag_error;

    logic       w_i_req;
    logic       w_d_req;
    logic       w_grant_i;
    logic       w_grant_d;
    logic [1:0] w_win_cmd;
    logic       w_accept;
    logic       w_cpl_hit;
    logic       w_cpl_owner;
    logic       w_cpl_miss;
    logic       w_dup_accept;

    // Grant decision, acceptance detection and completion lookup.
    always_comb begin
        w_i_req      = (bus.icache_command == BUS_LOAD);
        w_d_req      = (bus.dcache_command != BUS_NONE);
        w_grant_i    = w_i_req && (!w_d_req || (r_starve_cnt == STARVE_MAX));
        w_grant_d    = w_d_req && !w_grant_i;
        w_win_cmd    = w_grant_i ? BUS_LOAD : (w_grant_d ? bus.dcache_command : BUS_NONE);
        w_accept     = reset && (w_win_cmd == BUS_LOAD) && (bus.mem2proc_response != '0);
        w_cpl_hit    = 1'b0;
        w_cpl_owner  = 1'b0;
        w_dup_accept = 1'b0;
        if (bus.mem2proc_tag != '0) begin
            w_cpl_hit   = r_valid[bus.mem2proc_tag];
            w_cpl_owner = r_owner[bus.mem2proc_tag];
        end
        w_cpl_miss = reset && (bus.mem2proc_tag != '0) && !w_cpl_hit;
        // A tag freed by a completion in this same cycle may be reused at once.
        if (w_accept) begin
            w_dup_accept = r_valid[bus.mem2proc_response] &&
                           !(w_cpl_hit && (bus.mem2proc_tag == bus.mem2proc_response));
        end
    end

    // Drive bus outputs. Reset forces them all to zero, except the data broadcast.
    always_comb begin
        bus.icache_data      = bus.mem2proc_data;
        bus.dcache_data      = bus.mem2proc_data;
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.icache_response  = '0;
        bus.dcache_response  = '0;
        bus.icache_tag       = '0;
        bus.dcache_tag       = '0;
        bus.outstanding      = '0;
        bus.tag_error        = 1'b0;
        if (reset) begin
            bus.proc2mem_command = w_win_cmd;
            if (w_grant_i) begin
                bus.proc2mem_addr   = bus.icache_addr;
                bus.icache_response = bus.mem2proc_response;
            end else if (w_grant_d) begin
                bus.proc2mem_addr   = bus.dcache_addr;
                bus.proc2mem_data   = bus.dcache_wdata;
                bus.dcache_response = bus.mem2proc_response;
            end
            if (w_cpl_hit && !w_cpl_owner) bus.icache_tag = bus.mem2proc_tag;
            if (w_cpl_hit && w_cpl_owner)  bus.dcache_tag = bus.mem2proc_tag;
            bus.outstanding = r_valid;
            bus.tag_error   = r_tag_error;
        end
    end

    // Count consecutive icache losses, saturating at the limit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_i_req && !w_grant_i) begin
            if (r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + CW'(1);
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Tag table update. The acceptance write comes last, so it overrides a same-tag completion.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid <= '0;
            r_owner <= '0;
        end else begin
            if (w_cpl_hit) r_valid[bus.mem2proc_tag] <= 1'b0;
            if (w_accept) begin
                r_valid[bus.mem2proc_response] <= 1'b1;
                r_owner[bus.mem2proc_response] <= w_grant_d;
            end
        end
    end

    // Sticky error: completion of an unknown tag, or overwrite of a live tag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tag_error <= 1'b0;
        end else if (w_cpl_miss || w_dup_accept) begin
            r_tag_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Each stimulus cycle pushes its
// hand-computed expected outputs into a queue. A monitor pops and compares on
// the falling clock edge.
module tb_mem_bus_arbiter;
    localparam logic [1:0]  NONE  = 2'd0;
    localparam logic [1:0]  LOAD  = 2'd1;
    localparam logic [1:0]  STORE = 2'd2;
    localparam logic [63:0] WD    = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] WD2   = 64'hAAAA5555_AAAA5555;

    typedef struct {
        string       name;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] pdata;
        logic [3:0]  ir, dr, it, dt;
        logic [14:0] outst;
        logic        terr;
        logic [63:0] cdata;
    } exp_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: compares the DUT outputs with the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "cmd",   64'(bus.proc2mem_command), 64'(e.cmd));
                chk(e.name, "addr",  64'(bus.proc2mem_addr),    64'(e.addr));
                chk(e.name, "pdata", bus.proc2mem_data,         e.pdata);
                chk(e.name, "iresp", 64'(bus.icache_response),  64'(e.ir));
                chk(e.name, "dresp", 64'(bus.dcache_response),  64'(e.dr));
                chk(e.name, "itag",  64'(bus.icache_tag),       64'(e.it));
                chk(e.name, "dtag",  64'(bus.dcache_tag),       64'(e.dt));
                chk(e.name, "outst", 64'(bus.outstanding),      64'(e.outst));
                chk(e.name, "terr",  64'(bus.tag_error),        64'(e.terr));
                chk(e.name, "idata", bus.icache_data,           e.cdata);
                chk(e.name, "ddata", bus.dcache_data,           e.cdata);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input string nm, input logic rst,
                        input logic [1:0] ic, input logic [31:0] ia,
                        input logic [1:0] dc, input logic [31:0] da, input logic [63:0] wd,
                        input logic [3:0] resp, input logic [3:0] ctag,
                        input logic [1:0] ecmd, input logic [31:0] eaddr, input logic [63:0] epdata,
                        input logic [3:0] eir, input logic [3:0] edr,
                        input logic [3:0] eit, input logic [3:0] edt,
                        input logic [14:0] eout, input logic eterr);
        exp_t e;
        logic [63:0] cd;
        cd = 64'h01234567_89ABCDEF ^ {60'h0, ctag};
        @(posedge clock);
        #1;
        reset                 = rst;
        bus.icache_command    = ic;
        bus.icache_addr       = ia;
        bus.dcache_command    = dc;
        bus.dcache_addr       = da;
        bus.dcache_wdata      = wd;
        bus.mem2proc_response = resp;
        bus.mem2proc_tag      = ctag;
        bus.mem2proc_data     = cd;
        e.name = nm; e.cmd = ecmd; e.addr = eaddr; e.pdata = epdata;
        e.ir = eir; e.dr = edr; e.it = eit; e.dt = edt;
        e.outst = eout; e.terr = eterr; e.cdata = cd;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [14:0] eout, input logic eterr);
        step(nm, 1'b1, NONE, 32'h0, NONE, 32'h0, 64'h0, 4'd0, 4'd0,
             NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, eout, eterr);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus.icache_command = NONE; bus.icache_addr = '0;
        bus.dcache_command = NONE; bus.dcache_addr = '0; bus.dcache_wdata = '0;
        bus.mem2proc_response = '0; bus.mem2proc_tag = '0; bus.mem2proc_data = '0;

        // Reset: outputs forced low even with an active request.
        step("rst0", 0, LOAD, 32'h100, NONE, 0, 0, 4'd3, 4'd0, NONE, 0, 0, 0, 0, 0, 0, 15'h0, 0);
        step("rst1", 0, NONE, 0, STORE, 32'h200, WD, 4'd3, 4'd0, NONE, 0, 0, 0, 0, 0, 0, 15'h0, 0);

        // Icache-only load with tag 3, then its completion.
        step("iload", 1, LOAD, 32'h1238, NONE, 0, 0, 4'd3, 4'd0, LOAD, 32'h1238, 0, 4'd3, 0, 0, 0, 15'h0, 0);
        idle("iload_out", 15'h0004, 0);
        step("icpl3", 1, NONE, 0, NONE, 0, 0, 4'd0, 4'd3, NONE, 0, 0, 0, 0, 4'd3, 0, 15'h0004, 0);
        idle("icpl3_free", 15'h0, 0);

        // Dcache store: data forwarded, no table entry.
        step("dstore", 1, NONE, 0, STORE, 32'h2000, WD, 4'd7, 4'd0, STORE, 32'h2000, WD, 0, 4'd7, 0, 0, 15'h0, 0);
        idle("dstore_out", 15'h0, 0);

        // Interleaved: icache tag 2, dcache tag 9, completions 9 then 2.
        step("il_i2", 1, LOAD, 32'h3000, NONE, 0, 0, 4'd2, 4'd0, LOAD, 32'h3000, 0, 4'd2, 0, 0, 0, 15'h0, 0);
        step("il_d9", 1, NONE, 0, LOAD, 32'h4000, 0, 4'd9, 4'd0, LOAD, 32'h4000, 0, 0, 4'd9, 0, 0, 15'h0002, 0);
        step("il_c9", 1, NONE, 0, NONE, 0, 0, 4'd0, 4'd9, NONE, 0, 0, 0, 0, 0, 4'd9, 15'h0102, 0);
        step("il_c2", 1, NONE, 0, NONE, 0, 0, 4'd0, 4'd2, NONE, 0, 0, 0, 0, 4'd2, 0, 15'h0002, 0);
        idle("il_done", 15'h0, 0);

        // Same-tag reuse: completion of icache tag 4 with a new dcache acceptance of tag 4.
        step("re_i4", 1, LOAD, 32'h5000, NONE, 0, 0, 4'd4, 4'd0, LOAD, 32'h5000, 0, 4'd4, 0, 0, 0, 15'h0, 0);
        step("re_swap", 1, NONE, 0, LOAD, 32'h6000, 0, 4'd4, 4'd4, LOAD, 32'h6000, 0, 0, 4'd4, 4'd4, 0, 15'h0008, 0);
        idle("re_hold", 15'h0008, 0);
        step("re_dc4", 1, NONE, 0, NONE, 0, 0, 4'd0, 4'd4, NONE, 0, 0, 0, 0, 0, 4'd4, 15'h0008, 0);
        idle("re_done", 15'h0, 0);

        // Contention: dcache wins four, icache wins the fifth, twice over.
        for (int k = 1; k <= 10; k++) begin
            if (k == 5 || k == 10)
                step($sformatf("cont%0d", k), 1, LOAD, 32'h7000, STORE, 32'h8000, WD2, 4'd5, 4'd0,
                     LOAD, 32'h7000, 64'h0, 4'd5, 4'd0, 4'd0, 4'd0, 15'h0, 0);
            else if (k == 7)
                step($sformatf("cont%0d", k), 1, LOAD, 32'h7000, STORE, 32'h8000, WD2, 4'd5, 4'd5,
                     STORE, 32'h8000, WD2, 4'd0, 4'd5, 4'd5, 4'd0, 15'h0010, 0);
            else
                step($sformatf("cont%0d", k), 1, LOAD, 32'h7000, STORE, 32'h8000, WD2, 4'd5, 4'd0,
                     STORE, 32'h8000, WD2, 4'd0, 4'd5, 4'd0, 4'd0, (k == 6) ? 15'h0010 : 15'h0, 0);
        end
        idle("cont_out", 15'h0010, 0);

        // Reset mid-flight: tags 1 and 6 live, then reset, then a stale completion of 6.
        step("mr_c5", 1, NONE, 0, NONE, 0, 0, 4'd0, 4'd5, NONE, 0, 0, 0, 0, 4'd5, 0, 15'h0010, 0);
        step("mr_i1", 1, LOAD, 32'h9000, NONE, 0, 0, 4'd1, 4'd0, LOAD, 32'h9000, 0, 4'd1, 0, 0, 0, 15'h0, 0);
        step("mr_d6", 1, NONE, 0, LOAD, 32'hA000, 0, 4'd6, 4'd0, LOAD, 32'hA000, 0, 0, 4'd6, 0, 0, 15'h0001, 0);
        idle("mr_live", 15'h0021, 0);
        step("mr_rst", 0, LOAD, 32'hB000, NONE, 0, 0, 4'd2, 4'd1, NONE, 0, 0, 0, 0, 0, 0, 15'h0, 0);
        idle("mr_clear", 15'h0, 0);
        step("mr_c6", 1, NONE, 0, NONE, 0, 0, 4'd0, 4'd6, NONE, 0, 0, 0, 0, 0, 0, 15'h0, 0);
        idle("mr_err", 15'h0, 1);

        // An icache STORE is treated as no request.
        step("istore", 1, STORE, 32'hB000, NONE, 0, 0, 4'd3, 4'd0, NONE, 0, 0, 0, 0, 0, 0, 15'h0, 1);
        idle("end", 15'h0, 1);

        repeat (3) @(posedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single processor-to-memory bus between the instruction cache controller and the data cache controller. Each cycle it grants the bus to at most one requester and forwards that requester's command, address and store data. It passes the memory's same-cycle response tag back to the winner only. It records which requester owns each outstanding load tag, so that every later completion (`mem2proc_tag` / `mem2proc_data`) is delivered only to the requester that issued it. It sits between `icache`/`dcache` and the memory port at the top of the pipeline.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive lost contention cycles after which the icache is forced to win.
- `clock`  in  1  single system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; state is cleared on a posedge where `reset==0`.
- `icache_command`  in  2  BUS_NONE/BUS_LOAD (BUS_STORE from icache is treated as BUS_NONE).
- `icache_addr`  in  32  icache request address, 8-byte aligned.
- `dcache_command`  in  2  BUS_NONE/BUS_LOAD/BUS_STORE.
- `dcache_addr`  in  32  dcache request address.
- `dcache_wdata`  in  64  dcache store data.
- `mem2proc_response`  in  4  memory accept tag, same cycle as command; 0 = rejected.
- `mem2proc_data`  in  64  completion data.
- `mem2proc_tag`  in  4  completion tag; 0 = no completion.
- `proc2mem_command`  out  2  forwarded command of winner; BUS_NONE if no grant.
- `proc2mem_addr`  out  32  winner address; 0 if no grant.
- `proc2mem_data`  out  64  `dcache_wdata` when dcache wins, else 0.
- `icache_response`, `dcache_response`  out  4 each  `mem2proc_response` for the winner; 0 for the loser or an idle requester.
- `icache_tag`, `dcache_tag`  out  4 each  `mem2proc_tag` if owned by that requester, else 0.
- `icache_data`, `dcache_data`  out  64 each  `mem2proc_data` broadcast unconditionally.
- `outstanding`  out  15  bit t-1 set while tag t is an outstanding load.
- `tag_error`  out  1  sticky; set on a completion of an unrecorded tag.

## Operation
- Requesting means: icache is requesting when `icache_command==BUS_LOAD`; dcache is requesting when `dcache_command!=BUS_NONE`.
- Grant rules:
  - If only one requester is requesting, it wins.
  - If both are requesting, dcache wins unless `starve_cnt==STARVE_LIMIT`, in which case icache wins.
  - If neither is requesting, there is no grant.
- The loser sees response 0 and must retry; no queueing inside the block.
- `starve_cnt` (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating at `STARVE_LIMIT`, each cycle icache requests and loses.
  - Clears when icache wins, or when icache is not requesting.
  - Holds otherwise.
- Tag table: 15 entries, indexed by tags 1..15, each holding `valid` and `owner` (0 = icache, 1 = dcache).
  - Load accepted (winner is issuing a BUS_LOAD and `mem2proc_response!=0`): on the posedge, entry[response] gets valid=1 and owner=winner.
  - Accepted stores create no entry.
- Completion routing (combinational, from the registered table):
  - If `mem2proc_tag!=0` and entry valid, drive that tag on the owner's `*_tag` output; the other requester's `*_tag` is 0.
  - The entry is cleared on the posedge.
  - If the entry is invalid, both `*_tag` outputs are 0 and `tag_error` is set.
- Simultaneous events:
  - If a completion and a new acceptance use the same tag in one cycle, the new acceptance wins: entry valid=1 with the new owner.
  - An acceptance of a tag that is already valid overwrites it and sets `tag_error`.
- Reset:
  - Table cleared (all `outstanding` = 0), `starve_cnt` = 0, `tag_error` = 0.
  - While `reset==0`, all outputs except `*_data` are forced to 0/BUS_NONE.
  - A reset in the middle of a transaction discards ownership; a later completion of a pre-reset tag sets `tag_error`.

## Timing
- Grant, forwarding and response are zero-latency combinational: command in cycle N → `proc2mem_*` and `*_response` in cycle N.
- A table entry written at the end of cycle N can be routed from cycle N+1. Completion in the same cycle as acceptance is not supported and is flagged as `tag_error`.
- Completion routing is combinational from `mem2proc_tag` in the cycle it appears; the entry is freed at the next posedge.
- Reset values: `proc2mem_command` = BUS_NONE, `proc2mem_addr` = 0, `proc2mem_data` = 0, `*_response` = 0, `*_tag` = 0, `outstanding` = 0, `tag_error` = 0.

## Test plan
- Icache-only load:
  - Stimulus: `icache_command`=LOAD, addr=0x0000_1238, response=3.
  - Required: `proc2mem_addr`=0x1238, `icache_response`=3, `dcache_response`=0; next cycle `outstanding[2]`=1.
  - Later, `mem2proc_tag`=3 → `icache_tag`=3, `dcache_tag`=0; `outstanding`=0 after the posedge.
- Contention:
  - Stimulus: both request every cycle with response=5.
  - Required: dcache wins 4 cycles, icache wins the 5th, `starve_cnt` returns to 0, and the pattern repeats with STARVE_LIMIT=4.
- Dcache store:
  - Stimulus: `dcache_command`=STORE, `dcache_wdata`=0xDEADBEEF_CAFEF00D, response=7.
  - Required: `proc2mem_data` matches the store data, `dcache_response`=7, no `outstanding` bit is set.
- Interleaved completions:
  - Stimulus: icache load gets tag 2, dcache load gets tag 9; completions arrive in the order 9 then 2.
  - Required: `dcache_tag`=9 then `icache_tag`=2, never cross-delivered.
- Same-tag reuse:
  - Stimulus: completion tag=4 (owned by icache) in the same cycle as a dcache load accepted with response=4.
  - Required: this cycle `icache_tag`=4; next cycle entry 4 is valid with owner dcache; `tag_error`=0.
- Reset mid-flight:
  - Stimulus: tags 1 and 6 outstanding, `reset`=0 for one cycle, then `mem2proc_tag`=6.
  - Required: `outstanding`=0 after reset, both `*_tag`=0, `tag_error`=1.
